// File: rtl/ps2_scancode_decoder_pkg.sv
// ============================================================================
// ps2_scancode_decoder_pkg
// Scan-code set 2 constants, FSM encoding and event layout for the decoder.
// Optional build macro PS2_ASCII_EN adds the ASCII translation function.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_scancode_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam int EVT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
    endfunction

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] scan_to_ascii(input evt_t e);
        logic [7:0] a;
        a = 8'h00;
        if (!e.ext) begin
            case (e.code)
                8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d";
                8'h24: a = "e"; 8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h";
                8'h43: a = "i"; 8'h3B: a = "j"; 8'h42: a = "k"; 8'h4B: a = "l";
                8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o"; 8'h4D: a = "p";
                8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
                8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x";
                8'h35: a = "y"; 8'h1A: a = "z";
                8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
                8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
                8'h3E: a = "8"; 8'h46: a = "9";
                8'h29: a = 8'h20;
                8'h5A: a = 8'h0D;
                8'h66: a = 8'h08;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/ps2_scancode_decoder_if.sv
// ============================================================================
// ps2_scancode_decoder_if
// Scan-byte input and key-event output bundle. PS2_ASCII_EN adds oAscii.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ps2_scancode_decoder_if;

    logic [7:0] iScanCode;
    logic       iScanValid;
    logic       iEventReady;
    logic       oEventValid;
    logic [7:0] oKeyCode;
    logic       oExtended;
    logic       oBreak;
    logic [3:0] oKeyHeld;
    logic       oOverflow;
    logic       oError;
`ifdef PS2_ASCII_EN
    logic [7:0] oAscii;
`endif

    modport master (
        output iScanCode, iScanValid, iEventReady,
        input  oEventValid, oKeyCode, oExtended, oBreak, oKeyHeld, oOverflow, oError
`ifdef PS2_ASCII_EN
        , input oAscii
`endif
    );

    modport slave (
        input  iScanCode, iScanValid, iEventReady,
        output oEventValid, oKeyCode, oExtended, oBreak, oKeyHeld, oOverflow, oError
`ifdef PS2_ASCII_EN
        , output oAscii
`endif
    );

endinterface

`default_nettype wire

// File: rtl/ps2_scancode_decoder_fifo.sv
// ============================================================================
// ps2_scancode_decoder_fifo
// Synchronous first-word-fall-through FIFO with sticky overflow flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_decoder_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  wire logic             Clock,
    input  wire logic             Reset,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic             ovf_q;
    logic             w_pop, w_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign w_pop   = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge Clock) begin
        if (w_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (w_push) wr_q <= wr_q + PW'(1);
            if (w_pop)  rd_q <= rd_q + PW'(1);
            if (push_i && !w_push) ovf_q <= 1'b1;
        end
    end

    assign data_o     = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ============================================================================
// ps2_scancode_decoder
// Folds E0/F0/E1 prefixes into key events, buffers them, tracks W/A/S/D held.
// Build macro PS2_ASCII_EN adds the oAscii head-entry translation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input wire logic              Clock,
    input wire logic              Reset,
    ps2_scancode_decoder_if.slave bus
);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] held_q, held_d;
    logic       err_q, err_d;
    logic       push;
    evt_t       evt;
    evt_t       head;
    logic       fifo_full, fifo_empty, fifo_ovf;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        push    = 1'b0;
        evt     = '0;
        if (bus.iScanValid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iScanCode == SC_EXT)        state_d = ST_EXT;
                    else if (bus.iScanCode == SC_BRK)   state_d = ST_BRK;
                    else if (bus.iScanCode == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        cnt_d   = 3'd7;
                    end else begin
                        push = 1'b1;
                        evt  = '{ext: 1'b0, brk: 1'b0, code: bus.iScanCode};
                    end
                end
                ST_EXT: begin
                    if (bus.iScanCode == SC_BRK)        state_d = ST_EXTBRK;
                    else if (bus.iScanCode == SC_EXT)   state_d = ST_EXT;
                    else if (bus.iScanCode == SC_PAUSE) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        push    = 1'b1;
                        evt     = '{ext: 1'b1, brk: 1'b0, code: bus.iScanCode};
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXTBRK: begin
                    state_d = ST_IDLE;
                    if (is_prefix(bus.iScanCode)) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        evt  = '{ext: (state_q == ST_EXTBRK), brk: 1'b1, code: bus.iScanCode};
                    end
                end
                ST_SKIP: begin
                    // The Pause sequence is eight bytes with no release; report one make.
                    if (cnt_q == 3'd1) begin
                        push    = 1'b1;
                        evt     = '{ext: 1'b1, brk: 1'b0, code: SC_PAUSE};
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        held_d = held_q;
        if (push && !evt.ext) begin
            case (evt.code)
                SC_W:    held_d[0] = !evt.brk;
                SC_A:    held_d[1] = !evt.brk;
                SC_S:    held_d[2] = !evt.brk;
                SC_D:    held_d[3] = !evt.brk;
                default: held_d    = held_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            held_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            err_q   <= err_d;
        end
    end

    ps2_scancode_decoder_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock      (Clock),
        .Reset      (Reset),
        .push_i     (push),
        .data_i     (evt),
        .pop_i      (bus.iEventReady),
        .data_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    assign bus.oEventValid = !fifo_empty;
    assign bus.oKeyCode    = head.code;
    assign bus.oExtended   = head.ext;
    assign bus.oBreak      = head.brk;
    assign bus.oKeyHeld    = held_q;
    assign bus.oOverflow   = fifo_ovf;
    assign bus.oError      = err_q;
`ifdef PS2_ASCII_EN
    assign bus.oAscii      = fifo_empty ? 8'h00 : scan_to_ascii(head);
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

`default_nettype wire
